// File: rtl/instr_decode_ctrl.sv
// ---------------------------------------------------------------------------
// instr_decode_ctrl
// Instruction decoder and sequencing control for the 16-bit CPU; producing
// end of the ALU control interface.
//
// Sequence per instruction: FETCH -> DECODE -> REGREAD -> EXEC -> WB -> FETCH.
// Reserved opcodes take FETCH -> DECODE -> FETCH with an illegal pulse.
//
// Ports:
//   I_clk           clock, all registers on the rising edge
//   I_rst_n         asynchronous active-low reset
//   I_en            global enable; low freezes state and gates every strobe
//   I_instr         instruction word from instruction memory
//   I_instr_valid   I_instr valid this cycle (used only in FETCH)
//   I_shldBranch    ALU branch decision (used only in WB)
//   O_fetch_req     fetch request (FETCH)
//   O_state         current FSM state
//   O_aluop         {opcode, flag}
//   O_imm           instruction bits [7:0]
//   O_selD/A/B      destination / source register selects
//   O_regrd_en      register-file read strobe (REGREAD)
//   O_alu_en        ALU enable (EXEC)
//   O_regwe         register-file write strobe (WB, writing opcodes)
//   O_pc_op         00 hold, 01 increment, 10 load branch target
//   O_illegal       one-cycle pulse in DECODE on a reserved opcode
// ---------------------------------------------------------------------------
module instr_decode_ctrl #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned REGSEL_W = 3
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_en,
  input  logic [DATA_W-1:0]   I_instr,
  input  logic                I_instr_valid,
  input  logic                I_shldBranch,
  output logic                O_fetch_req,
  output logic [2:0]          O_state,
  output logic [4:0]          O_aluop,
  output logic [7:0]          O_imm,
  output logic [REGSEL_W-1:0] O_selD,
  output logic [REGSEL_W-1:0] O_selA,
  output logic [REGSEL_W-1:0] O_selB,
  output logic                O_regrd_en,
  output logic                O_alu_en,
  output logic                O_regwe,
  output logic [1:0]          O_pc_op,
  output logic                O_illegal
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REGREAD = 3'd3,
    S_EXEC    = 3'd4,
    S_WB      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'b00,
    PC_INC    = 2'b01,
    PC_BRANCH = 2'b10
  } pc_op_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [3:0]          opcode;
  logic                op_writing;
  logic                op_reserved;
  pc_op_e              pc_op;

  // Decoded fields come straight off the instruction register, which only
  // loads on the FETCH->DECODE edge, so they hold from DECODE to next DECODE.
  assign opcode  = ir_q[15:12];
  assign O_aluop = {opcode, ir_q[8]};
  assign O_imm   = ir_q[7:0];
  assign O_selD  = ir_q[11:9];
  assign O_selA  = ir_q[7:5];
  assign O_selB  = ir_q[4:2];
  assign O_state = state_q;
  assign O_pc_op = pc_op;

  assign op_writing  = (opcode inside {[4'd0:4'd5], [4'd8:4'd11]});
  assign op_reserved = (opcode inside {4'd6, 4'd7, 4'd14, 4'd15});

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    O_fetch_req = 1'b0;
    O_regrd_en  = 1'b0;
    O_alu_en    = 1'b0;
    O_regwe     = 1'b0;
    O_illegal   = 1'b0;
    pc_op       = PC_HOLD;
    if (I_en) begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          O_fetch_req = 1'b1;
          if (I_instr_valid) begin
            ir_d    = I_instr;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          if (op_reserved) begin
            O_illegal = 1'b1;
            pc_op     = PC_INC;
            state_d   = S_FETCH;
          end else begin
            state_d = S_REGREAD;
          end
        end
        S_REGREAD: begin
          O_regrd_en = 1'b1;
          state_d    = S_EXEC;
        end
        S_EXEC: begin
          O_alu_en = 1'b1;
          state_d  = S_WB;
        end
        S_WB: begin
          O_regwe = op_writing;
          pc_op   = I_shldBranch ? PC_BRANCH : PC_INC;
          state_d = S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
